// File: rtl/pig_status_tracker.sv
// Per-level pig alive/dying bookkeeping; hits collected per frame and committed on startOfFrame.
// Masks/score/kill_pulse update one cycle after the commit edge; pigs_left is combinational; no backpressure.
module pig_status_tracker #(
  parameter int                  MAX_PIGS     = 4,
  parameter int                  NUM_LEVELS   = 2,
  parameter logic [MAX_PIGS-1:0] LEVEL0_MASK  = 4'b0011,
  parameter logic [MAX_PIGS-1:0] LEVEL1_MASK  = 4'b1111,
  parameter int                  DEATH_FRAMES = 8,
  parameter int                  PIG_POINTS   = 500,
  parameter int                  SCORE_MAX    = 9999
) (
  input  logic                clk,
  input  logic                resetN,
  input  logic                startOfFrame,
  input  logic                collision_bird_pig,
  input  logic [2:0]          pig_index,
  input  logic [3:0]          current_level,
  output logic [MAX_PIGS-1:0] pig_alive_mask,
  output logic [MAX_PIGS-1:0] pig_dying_mask,
  output logic                pigs_left,
  output logic                kill_pulse,
  output logic [13:0]         score
);

  logic [MAX_PIGS-1:0]      alive_q, alive_d;
  logic [MAX_PIGS-1:0]      dying_q, dying_d;
  logic [MAX_PIGS-1:0]      pend_q, pend_d;
  logic [MAX_PIGS-1:0][3:0] cnt_q, cnt_d;
  logic [3:0]               level_q, level_d;
  logic [13:0]              score_q, score_d;
  logic                     kill_q, kill_d;
  logic [MAX_PIGS-1:0]      hit_vec;
  logic [MAX_PIGS-1:0]      kill_set;
  int                       n_kill;
  int                       score_sum;

  always_comb begin
    alive_d   = alive_q;
    dying_d   = dying_q;
    pend_d    = pend_q;
    cnt_d     = cnt_q;
    level_d   = level_q;
    score_d   = score_q;
    kill_d    = 1'b0;
    hit_vec   = '0;
    kill_set  = '0;
    n_kill    = 0;
    score_sum = 0;

    // Only live pigs can be hit; dying, dead and out-of-range slots are dropped here.
    for (int i = 0; i < MAX_PIGS; i++) begin
      hit_vec[i] = collision_bird_pig && (int'(pig_index) == i) && alive_q[i];
    end

    if (current_level != level_q) begin
      level_d = current_level;
      if (current_level == 4'd0)      alive_d = LEVEL0_MASK;
      else if (current_level == 4'd1) alive_d = LEVEL1_MASK;
      else                            alive_d = '0;
      dying_d = '0;
      pend_d  = '0;
      cnt_d   = '0;
    end else if (startOfFrame) begin
      kill_set = pend_q & alive_q;
      for (int i = 0; i < MAX_PIGS; i++) begin
        if (cnt_q[i] != 4'd0) begin
          cnt_d[i] = cnt_q[i] - 4'd1;
          if (cnt_q[i] == 4'd1) dying_d[i] = 1'b0;
        end
        // A fresh kill restarts the countdown regardless of the decrement above.
        if (kill_set[i]) begin
          alive_d[i] = 1'b0;
          dying_d[i] = 1'b1;
          cnt_d[i]   = 4'(DEATH_FRAMES);
          n_kill     = n_kill + 1;
        end
      end
      score_sum = int'(score_q) + PIG_POINTS * n_kill;
      score_d   = (score_sum > SCORE_MAX) ? 14'(SCORE_MAX) : 14'(score_sum);
      kill_d    = (n_kill != 0);
      pend_d    = hit_vec;
    end else begin
      pend_d = pend_q | hit_vec;
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      alive_q <= LEVEL0_MASK;
      dying_q <= '0;
      pend_q  <= '0;
      cnt_q   <= '0;
      level_q <= 4'd0;
      score_q <= 14'd0;
      kill_q  <= 1'b0;
    end else begin
      alive_q <= alive_d;
      dying_q <= dying_d;
      pend_q  <= pend_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      score_q <= score_d;
      kill_q  <= kill_d;
    end
  end

  // Held high across a level change and in game over so the controller never double-advances.
  assign pigs_left      = (|(alive_q | dying_q)) || (current_level != level_q) ||
                          (int'(current_level) >= NUM_LEVELS);
  assign pig_alive_mask = alive_q;
  assign pig_dying_mask = dying_q;
  assign kill_pulse     = kill_q;
  assign score          = score_q;

endmodule

// File: tb/tb_pig_status_tracker.sv
// Bench for pig_status_tracker: directed vector table, hand sequences, and randomized run vs a per-pig model.
module tb_pig_status_tracker;

  localparam int NP = 4;

  logic          clk;
  logic          resetN;
  logic          startOfFrame;
  logic          collision_bird_pig;
  logic [2:0]    pig_index;
  logic [3:0]    current_level;
  logic [NP-1:0] pig_alive_mask;
  logic [NP-1:0] pig_dying_mask;
  logic          pigs_left;
  logic          kill_pulse;
  logic [13:0]   score;

  pig_status_tracker dut (
    .clk                (clk),
    .resetN             (resetN),
    .startOfFrame       (startOfFrame),
    .collision_bird_pig (collision_bird_pig),
    .pig_index          (pig_index),
    .current_level      (current_level),
    .pig_alive_mask     (pig_alive_mask),
    .pig_dying_mask     (pig_dying_mask),
    .pigs_left          (pigs_left),
    .kill_pulse         (kill_pulse),
    .score              (score)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors;
  int miscompares;

  // Behavioural model: each pig has an alive flag and a count of death frames remaining.
  bit m_alive [NP];
  int m_left  [NP];
  bit m_pend  [NP];
  int m_level;
  int m_score;
  bit m_kill;

  function automatic int level_mask(int l);
    if (l == 0) return 3;
    if (l == 1) return 15;
    return 0;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NP; i++) begin
      m_alive[i] = level_mask(0)[i];
      m_left[i]  = 0;
      m_pend[i]  = 1'b0;
    end
    m_level = 0;
    m_score = 0;
    m_kill  = 1'b0;
  endtask

  function automatic int m_alive_int();
    int v = 0;
    for (int i = 0; i < NP; i++) if (m_alive[i]) v += (1 << i);
    return v;
  endfunction

  function automatic int m_dying_int();
    int v = 0;
    for (int i = 0; i < NP; i++) if (m_left[i] > 0) v += (1 << i);
    return v;
  endfunction

  function automatic int m_pigs_left(int lvl);
    return ((m_alive_int() | m_dying_int()) != 0 || lvl != m_level || lvl >= 2) ? 1 : 0;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step(input bit s, input bit c, input int idx, input int lvl);
    bit hit [NP];
    int nk;
    for (int i = 0; i < NP; i++) hit[i] = c && (idx == i) && m_alive[i];
    m_kill = 1'b0;
    if (lvl != m_level) begin
      m_level = lvl;
      for (int i = 0; i < NP; i++) begin
        m_alive[i] = level_mask(lvl)[i];
        m_left[i]  = 0;
        m_pend[i]  = 1'b0;
      end
    end else if (s) begin
      nk = 0;
      for (int i = 0; i < NP; i++) if (m_left[i] > 0) m_left[i]--;
      for (int i = 0; i < NP; i++) begin
        if (m_pend[i] && m_alive[i]) begin
          m_alive[i] = 1'b0;
          m_left[i]  = 8;
          nk++;
        end
        m_pend[i] = hit[i];
      end
      m_score = (m_score + 500 * nk > 9999) ? 9999 : m_score + 500 * nk;
      m_kill  = (nk > 0);
    end else begin
      for (int i = 0; i < NP; i++) m_pend[i] = m_pend[i] | hit[i];
    end
  endtask

  // Called one time unit after a rising edge; returns one time unit after the next rising edge.
  task automatic tick(input bit s, input bit c, input int idx, input int lvl);
    startOfFrame       = s;
    collision_bird_pig = c;
    pig_index          = 3'(idx);
    current_level      = 4'(lvl);
    #1;
    check("pigs_left_pre", int'(pigs_left), m_pigs_left(lvl));
    model_step(s, c, idx, lvl);
    @(posedge clk);
    #1;
    check("alive",          int'(pig_alive_mask), m_alive_int());
    check("dying",          int'(pig_dying_mask), m_dying_int());
    check("kill_pulse",     int'(kill_pulse),     int'(m_kill));
    check("score",          int'(score),          m_score);
    check("pigs_left_post", int'(pigs_left),      m_pigs_left(lvl));
  endtask

  typedef struct {
    bit s; bit c; int idx; int lvl;
    int alive; int dying; int kill; int score; int left;
  } vec_t;

  vec_t tab[$];

  function automatic vec_t mk(bit s, bit c, int idx, int lvl,
                              int alive, int dying, int kill, int sc, int left);
    vec_t v;
    v.s = s; v.c = c; v.idx = idx; v.lvl = lvl;
    v.alive = alive; v.dying = dying; v.kill = kill; v.score = sc; v.left = left;
    return v;
  endfunction

  int cur_lvl;

  initial begin
    vectors = 0;
    miscompares = 0;
    resetN = 1'b0;
    startOfFrame = 1'b0;
    collision_bird_pig = 1'b0;
    pig_index = 3'd0;
    current_level = 4'd0;
    model_reset();

    // Directed table: single kill, ignored hits, death countdown, same-cycle hit, level change.
    for (int k = 0; k < 5; k++) tab.push_back(mk(0, 1, 1, 0, 3, 0, 0, 0, 1));
    tab.push_back(mk(0, 1, 5, 0, 3, 0, 0, 0, 1));
    tab.push_back(mk(0, 1, 3, 0, 3, 0, 0, 0, 1));
    tab.push_back(mk(1, 0, 0, 0, 1, 2, 1, 500, 1));
    tab.push_back(mk(0, 1, 1, 0, 1, 2, 0, 500, 1));
    for (int k = 0; k < 7; k++) tab.push_back(mk(1, 0, 0, 0, 1, 2, 0, 500, 1));
    tab.push_back(mk(1, 0, 0, 0, 1, 0, 0, 500, 1));
    tab.push_back(mk(1, 1, 0, 0, 1, 0, 0, 500, 1));
    tab.push_back(mk(0, 0, 0, 0, 1, 0, 0, 500, 1));
    tab.push_back(mk(1, 0, 0, 0, 0, 1, 1, 1000, 1));
    for (int k = 0; k < 7; k++) tab.push_back(mk(1, 0, 0, 0, 0, 1, 0, 1000, 1));
    tab.push_back(mk(1, 0, 0, 0, 0, 0, 0, 1000, 0));
    tab.push_back(mk(0, 0, 0, 1, 15, 0, 0, 1000, 1));
    tab.push_back(mk(0, 1, 2, 1, 15, 0, 0, 1000, 1));
    tab.push_back(mk(1, 1, 3, 0, 3, 0, 0, 1000, 1));
    tab.push_back(mk(1, 0, 0, 0, 3, 0, 0, 1000, 1));

    #12;
    check("rst_alive", int'(pig_alive_mask), 3);
    check("rst_dying", int'(pig_dying_mask), 0);
    check("rst_score", int'(score), 0);
    check("rst_kill",  int'(kill_pulse), 0);
    check("rst_left",  int'(pigs_left), 1);
    resetN = 1'b1;
    @(posedge clk);
    #1;

    for (int k = 0; k < 10; k++) begin
      tick(1, 0, 0, 0);
      tick(0, 0, 0, 0);
    end
    check("idle_score", int'(score), 0);

    foreach (tab[k]) begin
      tick(tab[k].s, tab[k].c, tab[k].idx, tab[k].lvl);
      check($sformatf("tab%0d_alive", k), int'(pig_alive_mask), tab[k].alive);
      check($sformatf("tab%0d_dying", k), int'(pig_dying_mask), tab[k].dying);
      check($sformatf("tab%0d_kill",  k), int'(kill_pulse),     tab[k].kill);
      check($sformatf("tab%0d_score", k), int'(score),          tab[k].score);
      check($sformatf("tab%0d_left",  k), int'(pigs_left),      tab[k].left);
    end

    // Build the score up to 9500, then a 4-pig frame must saturate.
    for (int r = 0; r < 4; r++) begin
      tick(0, 0, 0, 1);
      for (int p = 0; p < NP; p++) tick(0, 1, p, 1);
      tick(1, 0, 0, 1);
      check("multi_kill_pulse", int'(kill_pulse), 1);
      tick(0, 0, 0, 0);
    end
    tick(0, 1, 0, 0);
    tick(1, 0, 0, 0);
    check("pre_sat_score", int'(score), 9500);
    tick(0, 0, 0, 1);
    for (int p = 0; p < NP; p++) tick(0, 1, p, 1);
    tick(1, 0, 0, 1);
    check("sat_score", int'(score), 9999);
    check("sat_alive", int'(pig_alive_mask), 0);
    check("sat_dying", int'(pig_dying_mask), 15);

    tick(0, 1, 0, 2);
    check("gameover_alive", int'(pig_alive_mask), 0);
    check("gameover_dying", int'(pig_dying_mask), 0);
    check("gameover_left",  int'(pigs_left), 1);
    for (int k = 0; k < 4; k++) tick(1, 1, k, 2);
    check("gameover_left_hold", int'(pigs_left), 1);
    check("gameover_score",     int'(score), 9999);

    // Randomized run with periodic asynchronous resets.
    cur_lvl = 0;
    for (int n = 0; n < 3000; n++) begin
      if (n % 700 == 350) begin
        startOfFrame = 1'b0;
        collision_bird_pig = 1'b0;
        current_level = 4'd0;
        cur_lvl = 0;
        #2;
        resetN = 1'b0;
        #1;
        check("async_rst_alive", int'(pig_alive_mask), 3);
        check("async_rst_score", int'(score), 0);
        check("async_rst_dying", int'(pig_dying_mask), 0);
        model_reset();
        #1;
        resetN = 1'b1;
        @(posedge clk);
        #1;
      end
      if ($urandom_range(0, 39) == 0) cur_lvl = $urandom_range(0, 3);
      tick(($urandom_range(0, 5) == 0), ($urandom_range(0, 2) == 0),
           $urandom_range(0, 7), cur_lvl);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
